// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM responder with valid/ready requests, programmable wait states and a load port.
// Optional MEM_RESPONDER_BUSERR_EN flags out-of-range accesses on rsp_err.
module mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic              w_accept, w_enter_resp, w_cur_we, w_cur_in, w_ld_in;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [DATA_W-1:0] w_cur_wdata;
    assign req_ready    = rst_n && (r_state == S_IDLE) && !ld_we;
    assign w_accept     = req_valid && req_ready;
    // With zero wait states the access commits on its acceptance edge, before the latches hold it.
    assign w_cur_we     = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_cur_addr   = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata  = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_cur_in     = (w_cur_addr >> DEPTH_LOG2) == '0;
    assign w_ld_in      = (ld_addr >> DEPTH_LOG2) == '0;
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_rdata    = r_rdata;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end
`ifdef MEM_RESPONDER_BUSERR_EN
    logic r_oor;
    assign rsp_err = rsp_valid && r_oor;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_oor <= 1'b0;
        else if (w_enter_resp) r_oor <= !w_cur_in;
    end
`else
    assign rsp_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_accept ? WAIT_INIT : ((r_state == S_WAIT) && (r_cnt != 4'd0)) ? r_cnt - 4'd1 : r_cnt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_enter_resp)
                r_rdata <= w_cur_we ? '0 : w_cur_in ? r_mem[w_cur_addr[DEPTH_LOG2-1:0]] : '1;
        end
    end
    // Request write is issued last so it wins a same-edge collision with the load port.
    always_ff @(posedge clk) begin
        if (ld_we && w_ld_in) r_mem[ld_addr[DEPTH_LOG2-1:0]] <= ld_wdata;
        if (w_enter_resp && w_cur_we && w_cur_in) r_mem[w_cur_addr[DEPTH_LOG2-1:0]] <= w_cur_wdata;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder; main instance with one wait state plus 0- and 5-wait-state instances.
module tb_mem_responder;
`ifdef MEM_RESPONDER_BUSERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    localparam int W = 1;
    typedef struct {
        logic [15:0] d;
        logic        e;
        int          c;
    } exp_t;
    exp_t q[$];
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, ld_we = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0, ld_addr = '0, ld_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        v0 = 1'b0, v5 = 1'b0, rdy0, rdy5, rv0, rv5, re0, re5;
    logic [15:0] rd0, rd5;
    int          cyc = 0, checks = 0, errors = 0, acc_cyc = 0, prev_acc = 0, ld_cyc = 0;
    logic        prev_v = 1'b0;

    mem_responder #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata));
    mem_responder #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_we(1'b0), .req_addr(16'hFFFF),
        .req_wdata(16'h0), .req_ready(rdy0), .rsp_valid(rv0), .rsp_rdata(rd0),
        .rsp_err(re0), .ld_we(1'b0), .ld_addr(16'h0), .ld_wdata(16'h0));
    mem_responder #(.WAIT_CYCLES(5)) u5 (
        .clk(clk), .rst_n(rst_n), .req_valid(v5), .req_we(1'b0), .req_addr(16'hFFFF),
        .req_wdata(16'h0), .req_ready(rdy5), .rsp_valid(rv5), .rsp_rdata(rd5),
        .rsp_err(re5), .ld_we(1'b0), .ld_addr(16'h0), .ld_wdata(16'h0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            check("rsp_width", {31'b0, prev_v}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rsp: got rsp_valid=1 expected no response");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, e.d});
                check("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
                check("rsp_cycle", cyc, e.c);
            end
        end
        prev_v = rsp_valid;
    end

    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_d, input logic exp_e);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        #1;
        for (int i = 0; i < 20 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
        end else begin
            q.push_back('{d: exp_d, e: exp_e, c: cyc + 1 + W});
            @(posedge clk);
            prev_acc = acc_cyc;
            acc_cyc = cyc;
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain", q.size(), 0);
    endtask

    task automatic sweep(input bit k, input int w);
        int lat;
        if (k) v5 = 1'b1; else v0 = 1'b1;
        #1;
        check("sweep_ready", {31'b0, k ? rdy5 : rdy0}, 32'd1);
        @(posedge clk); #1;
        if (k) v5 = 1'b0; else v0 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (k ? rv5 : rv0) lat = i;
        end
        check("sweep_latency", lat, w + 1);
        check("sweep_rdata", {16'b0, k ? rd5 : rd0}, 32'h0000FFFF);
        @(negedge clk);
        check("sweep_width", {31'b0, k ? rv5 : rv0}, 32'd0);
    endtask

    initial begin
        #3;
        check("reset_ready", {31'b0, req_ready}, 0);
        check("reset_valid", {31'b0, rsp_valid}, 0);
        check("reset_rdata", {16'b0, rsp_rdata}, 0);
        check("reset_err", {31'b0, rsp_err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 check("ready_after_reset", {31'b0, req_ready}, 1);
        @(posedge clk); #1;
        // Preload through the load port, then read it back.
        ld_we = 1'b1; ld_addr = 16'h0010; ld_wdata = 16'hBEEF;
        @(posedge clk); #1 ld_we = 1'b0;
        issue(1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0);
        // Back-to-back write then read.
        issue(1'b1, 16'h0123, 16'h5A5A, 16'h0000, 1'b0);
        issue(1'b0, 16'h0123, 16'h0, 16'h5A5A, 1'b0);
        check("b2b_accept_gap", acc_cyc - prev_acc, 3);
        drain();
        check("rdata_hold", {15'b0, rsp_valid, rsp_rdata}, 32'h00005A5A);
        // Out-of-range accesses must not alias onto address 0.
        issue(1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0);
        issue(1'b0, 16'h0400, 16'h0, 16'hFFFF, EXP_ERR);
        issue(1'b1, 16'h0400, 16'h2222, 16'h0000, EXP_ERR);
        issue(1'b0, 16'h0000, 16'h0, 16'h1111, 1'b0);
        drain();
        // Load port blocks acceptance for one cycle.
        ld_we = 1'b1; ld_addr = 16'h0020; ld_wdata = 16'h7777;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020;
        #1 check("ld_blocks_ready", {31'b0, req_ready}, 0);
        @(posedge clk);
        ld_cyc = cyc;
        #1 ld_we = 1'b0;
        issue(1'b0, 16'h0020, 16'h0, 16'h7777, 1'b0);
        check("accept_after_ld", acc_cyc, ld_cyc + 1);
        // Same-edge load and request write: request wins.
        issue(1'b1, 16'h0030, 16'hAAAA, 16'h0000, 1'b0);
        ld_we = 1'b1; ld_addr = 16'h0030; ld_wdata = 16'h5555;
        @(posedge clk); #1 ld_we = 1'b0;
        issue(1'b0, 16'h0030, 16'h0, 16'hAAAA, 1'b0);
        drain();
        // Asynchronous reset while waiting abandons the access.
        issue(1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("midwait_rst_valid", {31'b0, rsp_valid}, 0);
        check("midwait_rst_rdata", {16'b0, rsp_rdata}, 0);
        check("midwait_rst_ready", {31'b0, req_ready}, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("ready_after_rst2", {31'b0, req_ready}, 1);
        repeat (4) @(posedge clk);
        #1;
        sweep(1'b0, 0);
        sweep(1'b1, 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
